mc_alu_sequencer: RTL and testbench

Main control FSM of the multi-cycle ARM core. It sequences the shared ALU across fetch, decode, execute, memory and writeback steps, and drives the ALU operand muxes. It decodes data-processing commands into the 3-bit ALUControl encoding and flag-write enables. It sits between the instruction register and the datapath (ALU, register file, memory interface).

---
 rtl/mc_ctrl_pkg.sv | 117 +++++++++++
 rtl/mc_alu_decoder.sv | 55 +++++
 rtl/mc_alu_sequencer.sv | 83 ++++++++
 tb/tb_mc_alu_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle ARM main controller: state encodings,
// ALU control codes, data-processing commands, mux selects and per-state Moore outputs.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b111;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] MUL_BITS = 4'b1001;

    localparam logic [1:0] SRCA_RD1    = 2'd0;
    localparam logic [1:0] SRCA_PC     = 2'd1;
    localparam logic [1:0] SRCA_ALUOUT = 2'd2;

    localparam logic [1:0] SRCB_RD2    = 2'd0;
    localparam logic [1:0] SRCB_EXTIMM = 2'd1;
    localparam logic [1:0] SRCB_FOUR   = 2'd2;

    localparam logic [1:0] RES_ALUOUT    = 2'd0;
    localparam logic [1:0] RES_DATA      = 2'd1;
    localparam logic [1:0] RES_ALURESULT = 2'd2;

    typedef struct packed {
        logic       ir_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       alu_op;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.ir_write   = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
                c.next_pc    = 1'b1;
            end
            DECODE: begin
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
            end
            MEMADR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_EXTIMM;
            end
            MEMREAD: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_w      = 1'b1;
            end
            MEMWRITE: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
                c.mem_w      = 1'b1;
            end
            EXECUTER: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = 1'b1;
            end
            EXECUTEI: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_EXTIMM;
                c.alu_op    = 1'b1;
            end
            ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_w      = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a  = SRCA_RD1;
                c.alu_src_b  = SRCB_EXTIMM;
                c.result_src = RES_ALURESULT;
                c.branch     = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational data-processing decode: ALUControl, flag-write enables and a
// flag marking commands that must not write the register file.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic       alu_op,
    input  logic [5:0] funct,
    input  logic [3:0] mul_bits,
    output logic [2:0] alu_control,
    output logic [1:0] flag_w,
    output logic       no_write
);

    logic [3:0] cmd;
    logic       s_bit;
    logic       is_mul;
    logic       is_cmp;
    logic       known;
    logic [2:0] dp_ctrl;

    always_comb begin
        cmd     = funct[4:1];
        s_bit   = funct[0];
        // Only reached from EXECUTER/EXECUTEI, so Op=00 is implied here.
        is_mul  = ~funct[5] && (mul_bits == MUL_BITS);
        is_cmp  = ~is_mul && (cmd == CMD_CMP);
        known   = 1'b1;
        dp_ctrl = ALU_ADD;
        if (is_mul) begin
            dp_ctrl = ALU_MUL;
        end else begin
            case (cmd)
                CMD_ADD: dp_ctrl = ALU_ADD;
                CMD_SUB: dp_ctrl = ALU_SUB;
                CMD_CMP: dp_ctrl = ALU_SUB;
                CMD_AND: dp_ctrl = ALU_AND;
                CMD_ORR: dp_ctrl = ALU_ORR;
                CMD_EOR: dp_ctrl = ALU_EOR;
                default: known   = 1'b0;
            endcase
        end

        no_write    = is_cmp || !known;
        alu_control = ALU_ADD;
        flag_w      = 2'b00;
        if (alu_op) begin
            alu_control = dp_ctrl;
            if (is_cmp)
                flag_w = 2'b11;
            else
                flag_w = {s_bit, s_bit && (dp_ctrl == ALU_ADD || dp_ctrl == ALU_SUB)};
        end
    end

endmodule

// File: rtl/mc_alu_sequencer.sv
// Main control FSM of the multi-cycle ARM core: sequences fetch/decode/execute/
// memory/writeback and drives the datapath mux selects with registered outputs.
module mc_alu_sequencer
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         MulBits,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic [2:0]         ALUControl,
    output logic [1:0]         FlagW,
    output logic               NextPC,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic [STATE_W-1:0] state_o
);

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;
    logic   no_write;

    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH:    state_nxt = DECODE;
            DECODE: begin
                case (Op)
                    2'b00:   state_nxt = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_nxt = MEMADR;
                    2'b10:   state_nxt = BRANCH;
                    default: state_nxt = FETCH;
                endcase
            end
            MEMADR:   state_nxt = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_nxt = MEMWB;
            EXECUTER: state_nxt = ALUWB;
            EXECUTEI: state_nxt = ALUWB;
            default:  state_nxt = FETCH;
        endcase
    end

    // Outputs are registered from the next state, so they stay a pure function of state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            ctrl  <= state_ctrl(FETCH);
        end else begin
            state <= state_nxt;
            ctrl  <= state_ctrl(state_nxt);
        end
    end

    mc_alu_decoder u_alu_decoder (
        .alu_op      (ctrl.alu_op),
        .funct       (Funct),
        .mul_bits    (MulBits),
        .alu_control (ALUControl),
        .flag_w      (FlagW),
        .no_write    (no_write)
    );

    assign IRWrite   = ctrl.ir_write;
    assign AdrSrc    = ctrl.adr_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ResultSrc = ctrl.result_src;
    assign NextPC    = ctrl.next_pc;
    assign MemW      = ctrl.mem_w;
    assign Branch    = ctrl.branch;
    assign RegW      = ctrl.reg_w && !((state == ALUWB) && no_write);
    assign state_o   = STATE_W'(state);

endmodule

// File: tb/tb_mc_alu_sequencer.sv
// Directed self-checking bench for mc_alu_sequencer: walks each instruction class
// state by state and checks outputs and FETCH-to-FETCH cycle counts.
module tb_mc_alu_sequencer;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] MulBits;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [2:0] ALUControl;
    logic [1:0] FlagW;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic [3:0] state_o;

    int checks   = 0;
    int failures = 0;

    mc_alu_sequencer #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .MulBits    (MulBits),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .FlagW      (FlagW),
        .NextPC     (NextPC),
        .RegW       (RegW),
        .MemW       (MemW),
        .Branch     (Branch),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] mb);
        Op      = op;
        Funct   = funct;
        MulBits = mb;
    endtask

    // Counts edges from FETCH until FETCH is re-entered; also records any write pulse.
    task automatic run_len(input string tag, input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] mb, input int exp_len, input logic exp_wr);
        int   n;
        logic wr;
        set_instr(op, funct, mb);
        n  = 0;
        wr = 1'b0;
        do begin
            tick();
            n++;
            wr = wr | RegW | MemW;
        end while (state_o != 4'd0 && n < 20);
        check({tag, "_len"}, n, exp_len);
        check({tag, "_wr"}, {31'd0, wr}, {31'd0, exp_wr});
    endtask

    initial begin
        reset = 1'b1;
        set_instr(2'b00, 6'b001001, 4'b0000);
        #12;
        check("rst_state", state_o, 4'd0);
        check("rst_irwrite", IRWrite, 1'b1);
        check("rst_nextpc", NextPC, 1'b1);
        check("rst_srcb", ALUSrcB, 2'd2);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("rel_decode", state_o, 4'd1);
        check("decode_irwrite", IRWrite, 1'b0);
        tick();
        check("reach_exer", state_o, 4'd6);

        // Asynchronous reset in the middle of EXECUTER.
        reset = 1'b1;
        #1;
        check("async_rst_state", state_o, 4'd0);
        check("async_rst_irwrite", IRWrite, 1'b1);
        check("async_rst_nextpc", NextPC, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("post_rst_decode", state_o, 4'd1);

        // ADD with S, register operand.
        tick();
        check("add_state", state_o, 4'd6);
        check("add_aluctl", ALUControl, 3'b000);
        check("add_flagw", FlagW, 2'b11);
        check("add_srca", ALUSrcA, 2'd0);
        check("add_srcb", ALUSrcB, 2'd0);
        tick();
        check("add_wb_state", state_o, 4'd8);
        check("add_wb_regw", RegW, 1'b1);
        check("add_wb_flagw", FlagW, 2'b00);
        tick();
        check("add_fetch", state_o, 4'd0);

        // CMP immediate.
        set_instr(2'b00, 6'b110101, 4'b0000);
        tick();
        tick();
        check("cmp_state", state_o, 4'd7);
        check("cmp_aluctl", ALUControl, 3'b001);
        check("cmp_flagw", FlagW, 2'b11);
        check("cmp_srcb", ALUSrcB, 2'd1);
        tick();
        check("cmp_wb_regw", RegW, 1'b0);
        tick();

        // MUL.
        set_instr(2'b00, 6'b000000, 4'b1001);
        tick();
        tick();
        check("mul_aluctl", ALUControl, 3'b111);
        check("mul_flagw", FlagW, 2'b00);
        tick();
        check("mul_wb_regw", RegW, 1'b1);
        tick();

        // EOR with S.
        set_instr(2'b00, 6'b000011, 4'b0000);
        tick();
        tick();
        check("eor_aluctl", ALUControl, 3'b100);
        check("eor_flagw", FlagW, 2'b10);
        tick();
        tick();

        // Unsupported cmd 0110 with S: ADD code, no register write.
        set_instr(2'b00, 6'b001101, 4'b0000);
        tick();
        tick();
        check("unk_aluctl", ALUControl, 3'b000);
        check("unk_flagw", FlagW, 2'b11);
        tick();
        check("unk_wb_regw", RegW, 1'b0);
        tick();

        // LDR, with instruction inputs disturbed after MEMADR.
        set_instr(2'b01, 6'b011001, 4'b0000);
        tick();
        tick();
        check("ldr_memadr", state_o, 4'd2);
        check("ldr_memadr_srcb", ALUSrcB, 2'd1);
        check("ldr_memadr_aluctl", ALUControl, 3'b000);
        tick();
        check("ldr_memread", state_o, 4'd3);
        check("ldr_memread_adr", AdrSrc, 1'b1);
        set_instr(2'b11, 6'b000000, 4'b0000);
        tick();
        check("ldr_memwb", state_o, 4'd4);
        check("ldr_memwb_res", ResultSrc, 2'd1);
        check("ldr_memwb_regw", RegW, 1'b1);
        tick();
        check("ldr_fetch", state_o, 4'd0);

        // STR.
        set_instr(2'b01, 6'b011000, 4'b0000);
        tick();
        tick();
        tick();
        check("str_memwrite", state_o, 4'd5);
        check("str_memw", MemW, 1'b1);
        check("str_adr", AdrSrc, 1'b1);
        tick();

        // B.
        set_instr(2'b10, 6'b000000, 4'b0000);
        tick();
        tick();
        check("b_state", state_o, 4'd9);
        check("b_branch", Branch, 1'b1);
        check("b_res", ResultSrc, 2'd2);
        tick();
        check("b_fetch", state_o, 4'd0);
        check("fetch_irwrite", IRWrite, 1'b1);
        check("fetch_nextpc", NextPC, 1'b1);

        // FETCH-to-FETCH cycle counts per class.
        run_len("dp",    2'b00, 6'b001001, 4'b0000, 4, 1'b1);
        run_len("ldr",   2'b01, 6'b011001, 4'b0000, 5, 1'b1);
        run_len("str",   2'b01, 6'b011000, 4'b0000, 4, 1'b1);
        run_len("b",     2'b10, 6'b000000, 4'b0000, 3, 1'b0);
        run_len("undef", 2'b11, 6'b001001, 4'b0000, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
